// File: rtl/edge_bit_packer_pkg.sv
// Shared types and sizing helpers for the edge bit packer.
// Entry layout is {byte, eol, eof}; geometry follows the Sobel core's valid window.
// Helpers are constant functions so module parameters can drive them.
package edge_bit_packer_pkg;

  localparam int DEF_WIDTH  = 512;
  localparam int DEF_HEIGHT = 512;
  localparam int ENTRY_W    = 10;

  typedef struct packed {
    logic [7:0] dat;
    logic       eol;
    logic       eof;
  } entry_t;

  // Edge output dimension: the 3x3 core loses one pixel on each border.
  function automatic int out_dim(input int n);
    return n - 2;
  endfunction

  function automatic int bytes_per_row(input int ow);
    return (ow + 7) / 8;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_byte_fifo.sv
// Synchronous show-ahead FIFO; head entry visible combinationally, zero when empty.
// Latency: a push is visible at the head the cycle after the write edge.
// Push while full is only accepted together with a pop; pop while empty is ignored.
module edge_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push, do_pop;

  assign empty_o    = (wr_q == rd_q);
  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign head_dat_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/edge_bit_packer.sv
// Thresholds Sobel edge magnitudes to bits and packs them MSB-first into tagged bytes.
// Latency: byte written to FIFO on the edge of its last pixel; byte_valid one cycle later.
// Input cannot stall; when the FIFO is full without a pop the byte is dropped and overflow sticks.
module edge_bit_packer
  import edge_bit_packer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] edge_in,
  input  logic       edge_valid,
  input  logic [7:0] thresh,
  output logic [7:0] byte_out,
  output logic       byte_eol,
  output logic       byte_eof,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       overflow,
  output logic       frame_done
);

  localparam int OW = out_dim(WIDTH);
  localparam int OH = out_dim(HEIGHT);
  localparam int CW = cnt_w(OW);
  localparam int RW = cnt_w(OH);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);

  logic [CW-1:0] ocol_q, ocol_d;
  logic [RW-1:0] orow_q, orow_d;
  logic [7:0]    thr_q, thr_d;
  logic [7:0]    acc_q, acc_d;
  logic [2:0]    nbit_q, nbit_d;
  logic          ovf_q, fd_q;

  logic          pix_bit, row_end, push;
  entry_t        push_ent, head;
  logic          fifo_full, fifo_empty, pop, drop;

  // Threshold, accumulate and decide when a byte (full or row-final partial) is pushed.
  always_comb begin
    ocol_d   = ocol_q;
    orow_d   = orow_q;
    thr_d    = thr_q;
    acc_d    = acc_q;
    nbit_d   = nbit_q;
    pix_bit  = 1'b0;
    row_end  = 1'b0;
    push     = 1'b0;
    push_ent = '0;
    if (edge_valid) begin
      // The first pixel of a frame latches the threshold and uses it immediately.
      if (ocol_q == '0 && orow_q == '0) thr_d = thresh;
      pix_bit = (edge_in >= thr_d);
      acc_d   = {acc_q[6:0], pix_bit};
      row_end = (ocol_q == COL_LAST);
      if (nbit_q == 3'd7 || row_end) begin
        push         = 1'b1;
        // Left-align a partial byte; stale upper bits shift out the top.
        push_ent.dat = acc_d << (3'd7 - nbit_q);
        push_ent.eol = row_end;
        push_ent.eof = row_end && (orow_q == ROW_LAST);
        nbit_d       = '0;
      end else begin
        nbit_d = nbit_q + 3'd1;
      end
      if (row_end) begin
        ocol_d = '0;
        orow_d = (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
      end else begin
        ocol_d = ocol_q + 1'b1;
      end
    end
  end

  assign pop  = byte_ready && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  // Packing state, sticky overflow and the one-cycle frame_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocol_q <= '0;
      orow_q <= '0;
      thr_q  <= '0;
      acc_q  <= '0;
      nbit_q <= '0;
      ovf_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      ocol_q <= ocol_d;
      orow_q <= orow_d;
      thr_q  <= thr_d;
      acc_q  <= acc_d;
      nbit_q <= nbit_d;
      ovf_q  <= ovf_q | drop;
      fd_q   <= pop && head.eof;
    end
  end

  edge_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (byte_ready),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign byte_out   = head.dat;
  assign byte_eol   = head.eol;
  assign byte_eof   = head.eof;
  assign byte_valid = !fifo_empty;
  assign overflow   = ovf_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_edge_bit_packer.sv
// Randomized scoreboard bench for edge_bit_packer: a default-size instance and a 10x4 instance.
// Stimulus pushes expected bytes computed from pixel rules; a negedge monitor pops and compares.
module tb_edge_bit_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, v0, eol0, eof0, bv0, rdy0, ovf0, fd0;
  logic [7:0] in0, th0, out0;
  logic       rst1, v1, eol1, eof1, bv1, rdy1, ovf1, fd1;
  logic [7:0] in1, th1, out1;

  edge_bit_packer u_big (
    .clk(clk), .rst(rst0), .edge_in(in0), .edge_valid(v0), .thresh(th0),
    .byte_out(out0), .byte_eol(eol0), .byte_eof(eof0), .byte_valid(bv0),
    .byte_ready(rdy0), .overflow(ovf0), .frame_done(fd0)
  );

  edge_bit_packer #(.WIDTH(10), .HEIGHT(4)) u_small (
    .clk(clk), .rst(rst1), .edge_in(in1), .edge_valid(v1), .thresh(th1),
    .byte_out(out1), .byte_eol(eol1), .byte_eof(eof1), .byte_valid(bv1),
    .byte_ready(rdy1), .overflow(ovf1), .frame_done(fd1)
  );

  typedef struct packed {
    bit [7:0] dat;
    bit       eol;
    bit       eof;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  bit [7:0] log0[$];

  int m_ow[2], m_oh[2], m_col[2], m_row[2], m_val[2], m_n[2], m_thr[2];
  bit m_ovf[2], m_ovf_nxt[2], fd_exp[2];
  int pops[2], eol_cnt[2], fd_cnt[2];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int sb_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic model_reset(input int i);
    if (i == 0) sb0.delete(); else sb1.delete();
    m_col[i] = 0; m_row[i] = 0; m_val[i] = 0; m_n[i] = 0; m_thr[i] = 0;
    m_ovf[i] = 0; m_ovf_nxt[i] = 0; fd_exp[i] = 0;
  endtask

  // A byte enters the FIFO unless it is already full and nothing leaves this edge.
  task automatic model_push(input int i, input exp_t e, input bit rdy);
    int sz;
    sz = sb_size(i);
    if (sz == 16 && !(rdy && sz > 0)) m_ovf_nxt[i] = 1'b1;
    else if (i == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  // Reference: bits of a row are collected as an integer, flushed every 8 bits or at row end.
  task automatic model_pixel(input int i, input int pix, input int th, input bit rdy);
    exp_t e;
    bit   b, last;
    if (m_col[i] == 0 && m_row[i] == 0) m_thr[i] = th;
    b = (pix >= m_thr[i]);
    m_val[i] = m_val[i] * 2 + int'(b);
    m_n[i]++;
    last = (m_col[i] == m_ow[i] - 1);
    if (m_n[i] == 8 || last) begin
      e.dat = 8'(m_val[i] * (1 << (8 - m_n[i])));
      e.eol = last;
      e.eof = last && (m_row[i] == m_oh[i] - 1);
      model_push(i, e, rdy);
      m_val[i] = 0;
      m_n[i]   = 0;
    end
    if (last) begin
      m_col[i] = 0;
      m_row[i] = (m_row[i] + 1) % m_oh[i];
    end else begin
      m_col[i]++;
    end
  endtask

  // Drive one cycle on instance i (called at posedge+1, returns at next posedge+1).
  task automatic step(input int i, input bit vld, input int pix, input int th, input bit rdy);
    m_ovf_nxt[i] = m_ovf[i];
    if (i == 0) begin
      v0 = vld; in0 = 8'(pix); th0 = 8'(th); rdy0 = rdy; v1 = 1'b0;
    end else begin
      v1 = vld; in1 = 8'(pix); th1 = 8'(th); rdy1 = rdy; v0 = 1'b0;
    end
    if (vld) model_pixel(i, pix, th, rdy);
    @(posedge clk);
    #1;
    m_ovf[i] = m_ovf_nxt[i];
  endtask

  task automatic drain(input int i, input string name);
    int n;
    n = 0;
    while ((sb_size(i) != 0) && n < 300) begin
      step(i, 1'b0, 0, 0, 1'b1);
      n++;
    end
    step(i, 1'b0, 0, 0, 1'b1);
    chk({name, "_drain_left"}, sb_size(i), 0);
  endtask

  task automatic mon(input int i, input logic bv, input logic rdy, input logic [7:0] d,
                     input logic eol, input logic eof, input logic ovf, input logic fd);
    exp_t e;
    chk((i == 0) ? "frame_done0" : "frame_done1", int'(fd), int'(fd_exp[i]));
    chk((i == 0) ? "overflow0" : "overflow1", int'(ovf), int'(m_ovf[i]));
    if (fd) fd_cnt[i]++;
    fd_exp[i] = 1'b0;
    if (bv && rdy) begin
      if (sb_size(i) == 0) begin
        chk((i == 0) ? "unexpected_byte0" : "unexpected_byte1", int'(d), -1);
      end else begin
        e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
        chk((i == 0) ? "byte0" : "byte1", int'(d), int'(e.dat));
        chk((i == 0) ? "eol0" : "eol1", int'(eol), int'(e.eol));
        chk((i == 0) ? "eof0" : "eof1", int'(eof), int'(e.eof));
        fd_exp[i] = e.eof;
        pops[i]++;
        if (eol) eol_cnt[i]++;
        if (i == 0) log0.push_back(d);
      end
    end
  endtask

  // Monitor: compares every presented-and-accepted byte plus the status flags.
  always @(negedge clk) begin
    if (!rst0) mon(0, bv0, rdy0, out0, eol0, eof0, ovf0, fd0);
    if (!rst1) mon(1, bv1, rdy1, out1, eol1, eof1, ovf1, fd1);
  end

  task automatic chk_zero(input string name, input int i);
    if (i == 0) chk(name, {out0, eol0, eof0, bv0, ovf0, fd0}, 0);
    else chk(name, {out1, eol1, eof1, bv1, ovf1, fd1}, 0);
  endtask

  initial begin
    int p0, e0, bad;
    rst0 = 1'b1; rst1 = 1'b1;
    v0 = 0; in0 = 0; th0 = 0; rdy0 = 1; v1 = 0; in1 = 0; th1 = 0; rdy1 = 1;
    m_ow[0] = 510; m_oh[0] = 510; m_ow[1] = 8; m_oh[1] = 2;
    model_reset(0);
    model_reset(1);
    #1;
    chk_zero("reset_outputs_big", 0);
    chk_zero("reset_outputs_small", 1);
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;

    // Row of all-strong pixels: 63 x 0xFF then 0xFC with eol.
    p0 = pops[0];
    for (int c = 0; c < 510; c++) step(0, 1'b1, 200, 100, 1'b1);
    drain(0, "row_ff");
    chk("row_ff_count", pops[0] - p0, 64);
    chk("row_ff_last", int'(log0[log0.size() - 1]), 8'hFC);

    // Alternating pixels, with the byte-completion latency probed on the first byte.
    for (int c = 0; c < 510; c++) begin
      step(0, 1'b1, (c % 2 == 1) ? 255 : 0, 100, 1'b1);
      if (c == 6) chk("latency_before", int'(bv0), 0);
      if (c == 7) chk("latency_after", int'(bv0), 1);
    end
    drain(0, "row_alt");
    chk("row_alt_first", int'(log0[64]), 8'h55);

    // Threshold equality then a mid-frame threshold change that must not take effect.
    p0 = pops[0];
    step(0, 1'b1, 100, 100, 1'b1);
    for (int c = 1; c < 8; c++) step(0, 1'b1, 99, 0, 1'b1);
    for (int c = 8; c < 510; c++) step(0, 1'b1, $urandom_range(255), $urandom_range(255), 1'b1);
    drain(0, "row_thr");
    chk("thr_first_byte", int'(log0[p0]), 8'h80);

    // Backpressure: 16 bytes kept, the rest dropped, overflow sticks.
    p0 = pops[0];
    for (int c = 0; c < 510; c++) step(0, 1'b1, 255, 7, 1'b0);
    chk("bp_valid", int'(bv0), 1);
    chk("bp_overflow", int'(ovf0), 1);
    drain(0, "bp");
    chk("bp_count", pops[0] - p0, 16);
    bad = 0;
    for (int k = p0; k < pops[0]; k++) if (log0[k] != 8'hFF) bad++;
    chk("bp_bytes_ff", bad, 0);
    chk("bp_overflow_held", int'(ovf0), 1);

    // Reset mid-row with bytes buffered: outputs clear without a clock edge.
    for (int c = 0; c < 20; c++) step(0, 1'b1, $urandom_range(255), 50, 1'b0);
    rst0 = 1'b1;
    model_reset(0);
    #1;
    chk_zero("async_reset_outputs", 0);
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    p0 = pops[0];
    e0 = eol_cnt[0];
    for (int c = 0; c < 510; c++) step(0, 1'b1, $urandom_range(255), $urandom_range(255), 1'b1);
    drain(0, "post_reset");
    chk("post_reset_count", pops[0] - p0, 64);
    chk("post_reset_eol", eol_cnt[0] - e0, 1);

    // Random gaps and random downstream readiness.
    for (int c = 0; c < 3 * 510; c++) begin
      if ($urandom_range(9) < 7) step(0, 1'b1, $urandom_range(255), $urandom_range(255), 1'(($urandom_range(1))));
      else step(0, 1'b0, 0, 0, 1'(($urandom_range(1))));
    end
    drain(0, "random_big");

    // Small frame: two rows of one byte each, frame_done once.
    p0 = pops[1];
    for (int c = 0; c < 16; c++) step(1, 1'b1, 5, 1, 1'b1);
    drain(1, "small_frame");
    chk("small_count", pops[1] - p0, 2);
    chk("small_fd_count", fd_cnt[1], 1);

    // Two more small frames under random readiness.
    for (int c = 0; c < 32; c++) begin
      step(1, 1'b1, $urandom_range(255), $urandom_range(255), 1'(($urandom_range(1))));
      if ($urandom_range(3) == 0) step(1, 1'b0, 0, 0, 1'(($urandom_range(1))));
    end
    drain(1, "small_random");
    chk("small_fd_total", fd_cnt[1], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_bit_packer.md
Name: edge_bit_packer

Overview:
- Downstream consumer of the Sobel core's edge stream (pixel_out/valid_out).
- Thresholds each 8-bit gradient magnitude to one bit and packs 8 bits per byte, MSB first.
- Tags row-end and frame-end, and buffers bytes in a small FIFO behind a ready/valid output.
- Provides backpressure decoupling, because the Sobel core cannot stall.

Parameters:
- WIDTH, 512: input image width; the core emits OW = WIDTH-2 edge pixels per row.
- HEIGHT, 512: input image height; the core emits OH = HEIGHT-2 edge rows per frame.
- FIFO_DEPTH, 16: output FIFO entries; must be a power of two, at least 2.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- edge_in, input, 8: gradient magnitude from the Sobel core.
- edge_valid, input, 1: edge_in is valid this cycle; no backpressure on this input.
- thresh, input, 8: edge threshold.
- byte_out, output, 8: packed edge bits; bit7 holds the earliest pixel.
- byte_eol, output, 1: byte_out is the last byte of an edge row.
- byte_eof, output, 1: byte_out is the last byte of the frame.
- byte_valid, output, 1: FIFO not empty.
- byte_ready, input, 1: downstream accepts; a pop occurs when byte_valid && byte_ready.
- overflow, output, 1: sticky flag; a packed byte was dropped.
- frame_done, output, 1: one-cycle pulse when the eof byte is popped.

Behaviour:
- Reset:
  - byte_out=0, byte_eol=0, byte_eof=0, byte_valid=0, overflow=0, frame_done=0.
  - FIFO emptied; ocol=0, orow=0; bit accumulator cleared; thresh latch=0.
  - A reset mid-frame discards all partial and buffered data. The next edge_valid is treated as col 0, row 0 of a new frame.
- Threshold:
  - bit = (edge_in >= thr_q), unsigned compare.
  - thr_q captures thresh on the first edge_valid of each frame (ocol==0 && orow==0), and that cycle's pixel uses the new value.
  - thr_q is constant for the rest of the frame.
- Packing, on each edge_valid:
  - Shift the bit into the accumulator; increment bit count; advance ocol.
  - Push condition: bit count reaches 8, or ocol==OW-1.
  - Push entry: {byte, eol, eof}. A partial byte is left-aligned with zero fill in the low bits.
  - eol=1 iff ocol==OW-1. eof=1 iff eol && orow==OH-1.
  - After the push, the bit count returns to 0.
  - ocol wraps to 0 at OW-1 and orow increments. orow wraps to 0 after OH-1.
  - Bytes per row = ceil(OW/8); 64 for the defaults.
- Latency: a pixel that completes a byte on edge N is written to the FIFO at edge N. With the FIFO previously empty, byte_valid is 1 in the following cycle.
- FIFO:
  - Show-ahead: byte_out, byte_eol and byte_eof reflect the head entry whenever byte_valid=1.
  - Outputs are held stable while byte_valid && !byte_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full (no drop).
  - Push when full with no pop: the entry is dropped, overflow is set to 1 and held until rst; FIFO contents are unchanged.
  - Pop when empty is ignored.
- Counters: ocol and orow advance on every edge_valid, regardless of overflow, so framing stays aligned to the Sobel core.
- frame_done: asserted on the cycle after the eof entry is popped, for exactly one cycle.
- Gaps with edge_valid=0 of any length are allowed; no timeout.

Decomposition:
- Shared package holds:
  - OW = WIDTH-2, OH = HEIGHT-2, BYTES_PER_ROW = (OW+7)/8.
  - FIFO entry width = 10 (byte, eol, eof).
  - Counter widths via $clog2.
- One sub-module: edge_byte_fifo, a synchronous show-ahead FIFO with async active-high reset and full/empty outputs. The packing logic and counters stay in edge_bit_packer.

Test Plan:
- Default params, thresh=100, byte_ready=1, one row of 510 pixels all 200 → 63 bytes of 0xFF (eol=0), then 0xFC with eol=1 and eof=0; overflow stays 0.
- Alternating pixels 0,255,0,255,… with thresh=100 → every full byte is 0x55. A single pixel on edge N gives byte_valid=1 one cycle later once 8 pixels are collected.
- Threshold edge case: thresh=100 with pixels 100 then 99 ×7 → byte 0x80. Change thresh to 0 mid-frame → output is unchanged until the next frame start.
- Backpressure: byte_ready=0 while a 510-pixel row of 255 enters → first 16 bytes are buffered and byte 17 onward are dropped with overflow=1. Then byte_ready=1 drains exactly 16 bytes of 0xFF in order; overflow remains 1.
- WIDTH=10, HEIGHT=4, thresh=1, all pixels 5 → two bytes 0xFF. First has eol=1, eof=0; second has eol=1, eof=1. frame_done pulses once, the cycle after the second pop.
- Assert rst after 20 pixels of a row → all outputs are 0 immediately (async). After release, 510 fresh pixels produce exactly 64 bytes, with eol only on the 64th.
